// File: rtl/led_event_blinker.sv
// Event-driven LED blinker: each event produces one ON_CYCLES-long blink followed by an
// OFF_CYCLES gap; events arriving during a blink are queued in a saturating pending counter.
module led_event_blinker #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt,
  input  logic             clr_ovf,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0]    ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]    OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] PMAX     = {CNT_W{1'b1}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             ovf_q, ovf_d;
  logic             inc;
  logic             ovf_set;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    led_d     = led_q;
    busy_d    = busy_q;
    pending_d = pending_q;
    inc       = 1'b0;
    ovf_set   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (evt) begin
          state_d = ST_ON;
          timer_d = ON_LOAD;
          led_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_ON: begin
        inc = evt;
        if (timer_q == '0) begin
          state_d = ST_GAP;
          timer_d = OFF_LOAD;
          led_d   = 1'b0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == '0) begin
          // Final gap cycle: a queued blink wins, and a coincident evt replaces the one consumed.
          if (pending_q != '0) begin
            state_d = ST_ON;
            timer_d = ON_LOAD;
            led_d   = 1'b1;
            if (!evt) pending_d = pending_q - CNT_W'(1);
          end else if (evt) begin
            state_d = ST_ON;
            timer_d = ON_LOAD;
            led_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          timer_d = timer_q - TW'(1);
          inc     = evt;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        timer_d   = '0;
        led_d     = 1'b0;
        busy_d    = 1'b0;
        pending_d = '0;
      end
    endcase

    if (inc) begin
      if (pending_q == PMAX) ovf_set = 1'b1;
      else                   pending_d = pending_q + CNT_W'(1);
    end

    ovf_d = (ovf_q & ~clr_ovf) | ovf_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign led       = led_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule
